// File: rtl/datapath_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | datapath_controller: IR + Moore sequencer for MOV/ALU on the 16-bit path.   |
// | Optional illegal-opcode trap: ILLEGAL_TRAP_EN.        Revision: 1.0         |
// +----------------------------------------------------------------------------+
module datapath_controller #(
  parameter logic [2:0] OPC_MOV = 3'b110,
  parameter logic [2:0] OPC_ALU = 3'b101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] instr,
  output logic        w,
  output logic        err,
  output logic [15:0] datapath_in,
  output logic        vsel,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic        loads,
  output logic        loadc,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_WR_IMM = 3'd2,
    S_GET_A  = 3'd3,
    S_GET_B  = 3'd4,
    S_EXEC   = 3'd5,
`ifdef ILLEGAL_TRAP_EN
    S_WR_REG = 3'd6,
    S_TRAP   = 3'd7
`else
    S_WR_REG = 3'd6
`endif
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [15:0] ir;

  logic [2:0] opc;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;
  logic       is_alu;
  logic       is_mov;

  assign opc    = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign is_alu = (opc == OPC_ALU);
  assign is_mov = (opc == OPC_MOV);

  assign datapath_in = {{8{ir[7]}}, ir[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= 16'h0000;
    end else begin
      state <= next_state;
      // IR only accepts a new word while idle; this also covers load+s on the same edge.
      if (load && (state == S_WAIT)) begin
        ir <= instr;
      end
    end
  end

  always_comb begin
    next_state = S_WAIT;
    w          = 1'b0;
    vsel       = 1'b0;
    write      = 1'b0;
    loada      = 1'b0;
    loadb      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    loads      = 1'b0;
    loadc      = 1'b0;
    writenum   = 3'd0;
    readnum    = 3'd0;
    shift      = 2'd0;
    ALUop      = 2'd0;

    case (state)
      S_WAIT: begin
        w          = 1'b1;
        next_state = s ? S_DECODE : S_WAIT;
      end
      S_DECODE: begin
        if (is_mov && (op == 2'b10)) begin
          next_state = S_WR_IMM;
        end else if (is_mov && (op == 2'b00)) begin
          next_state = S_GET_B;
        end else if (is_alu && (op == 2'b11)) begin
          next_state = S_GET_B;
        end else if (is_alu) begin
          next_state = S_GET_A;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          next_state = S_TRAP;
`else
          next_state = S_WAIT;
`endif
        end
      end
      S_WR_IMM: begin
        vsel       = 1'b1;
        write      = 1'b1;
        writenum   = rn;
        next_state = S_WAIT;
      end
      S_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        next_state = S_GET_B;
      end
      S_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        next_state = S_EXEC;
      end
      S_EXEC: begin
        shift = sh;
        if (is_alu) begin
          ALUop = op;
        end else begin
          // MOV register passes Rm through the shifter by adding it to a zeroed A.
          asel = 1'b1;
        end
        if (is_alu && (op == 2'b01)) begin
          loads      = 1'b1;
          next_state = S_WAIT;
        end else begin
          loadc      = 1'b1;
          next_state = S_WR_REG;
        end
      end
      S_WR_REG: begin
        write      = 1'b1;
        writenum   = rd;
        next_state = S_WAIT;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        next_state = S_TRAP;
      end
`endif
      default: begin
        next_state = S_WAIT;
      end
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign err = (state == S_TRAP);
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_datapath_controller.sv
`default_nettype none
// Directed, table-driven bench for datapath_controller; compares every output each cycle.
module tb_datapath_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s = 1'b0;
  logic        load = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        w, err, vsel, write, loada, loadb, asel, bsel, loads, loadc;
  logic [2:0]  writenum, readnum;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;
  logic [35:0] act;

  int nvec = 0;
  int nerr = 0;

  datapath_controller dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .instr(instr),
    .w(w), .err(err), .datapath_in(datapath_in),
    .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .loads(loads), .loadc(loadc),
    .writenum(writenum), .readnum(readnum), .shift(shift), .ALUop(ALUop)
  );

  always #5 clk = ~clk;

  assign act = {w, err, vsel, write, loada, loadb, asel, bsel, loads, loadc,
                writenum, readnum, shift, ALUop, datapath_in};

  // ctl = {vsel, write, loada, loadb, asel, bsel, loads, loadc}
  function automatic logic [35:0] ex(input logic ew, input logic eerr, input logic [7:0] ctl,
                                     input logic [2:0] wn, input logic [2:0] rn,
                                     input logic [1:0] sh, input logic [1:0] alu,
                                     input logic [15:0] dp);
    return {ew, eerr, ctl, wn, rn, sh, alu, dp};
  endfunction

  function automatic logic [35:0] idle(input logic [15:0] dp);
    return ex(1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 2'd0, 2'd0, dp);
  endfunction

  function automatic logic [35:0] busy(input logic [15:0] dp);
    return ex(1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 2'd0, 2'd0, dp);
  endfunction

  typedef struct packed {
    logic        rst;
    logic        ld;
    logic        st;
    logic [15:0] ins;
    logic [35:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic ld, input logic st,
                     input logic [15:0] ins, input logic [35:0] e);
    vec_t v;
    v.rst = r; v.ld = ld; v.st = st; v.ins = ins; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic step(input logic r, input logic ld, input logic st,
                      input logic [15:0] ins, input logic [35:0] e, input int tag);
    reset = r; load = ld; s = st; instr = ins;
    @(posedge clk);
    #1;
    nvec++;
    if (act !== e) begin
      nerr++;
      $display("FAIL vec%0d: outputs got %h expected %h", tag, act, e);
    end
  endtask

  initial begin
    logic [15:0] bad [2];
    bad[0] = 16'h0000;
    bad[1] = 16'hC800;

    // reset and idle
    add(1, 0, 0, 16'h0000, idle(16'h0000));
    add(1, 0, 0, 16'h0000, idle(16'h0000));
    add(0, 0, 0, 16'h0000, idle(16'h0000));
    // MOV R0, #7
    add(0, 1, 1, 16'hD007, busy(16'h0007));
    add(0, 0, 0, 16'h0000, ex(0, 0, 8'hC0, 3'd0, 3'd0, 2'd0, 2'd0, 16'h0007));
    add(0, 0, 0, 16'h0000, idle(16'h0007));
    // MOV R1, #-2
    add(0, 1, 1, 16'hD1FE, busy(16'hFFFE));
    add(0, 0, 0, 16'h0000, ex(0, 0, 8'hC0, 3'd1, 3'd0, 2'd0, 2'd0, 16'hFFFE));
    add(0, 0, 0, 16'h0000, idle(16'hFFFE));
    // ADD R2, R1, R0 LSL#1; load/s while busy are ignored
    add(0, 1, 1, 16'hA148, busy(16'h0048));
    add(0, 1, 1, 16'h0000, ex(0, 0, 8'h20, 3'd0, 3'd1, 2'd0, 2'd0, 16'h0048));
    add(0, 0, 1, 16'h0000, ex(0, 0, 8'h10, 3'd0, 3'd0, 2'd0, 2'd0, 16'h0048));
    add(0, 0, 0, 16'h0000, ex(0, 0, 8'h01, 3'd0, 3'd0, 2'b01, 2'b00, 16'h0048));
    add(0, 0, 0, 16'h0000, ex(0, 0, 8'h40, 3'd2, 3'd0, 2'd0, 2'd0, 16'h0048));
    add(0, 0, 0, 16'h0000, idle(16'h0048));
    // CMP R0, R0
    add(0, 1, 1, 16'hA800, busy(16'h0000));
    add(0, 0, 0, 16'h0000, ex(0, 0, 8'h20, 3'd0, 3'd0, 2'd0, 2'd0, 16'h0000));
    add(0, 0, 0, 16'h0000, ex(0, 0, 8'h10, 3'd0, 3'd0, 2'd0, 2'd0, 16'h0000));
    add(0, 0, 0, 16'h0000, ex(0, 0, 8'h02, 3'd0, 3'd0, 2'd0, 2'b01, 16'h0000));
    add(0, 0, 0, 16'h0000, idle(16'h0000));
    // MOV R2, R3 LSL#1 with s held: restarts immediately after WAIT
    add(0, 1, 1, 16'hC04B, busy(16'h004B));
    add(0, 0, 1, 16'h0000, ex(0, 0, 8'h10, 3'd0, 3'd3, 2'd0, 2'd0, 16'h004B));
    add(0, 0, 1, 16'h0000, ex(0, 0, 8'h09, 3'd0, 3'd0, 2'b01, 2'b00, 16'h004B));
    add(0, 0, 1, 16'h0000, ex(0, 0, 8'h40, 3'd2, 3'd0, 2'd0, 2'd0, 16'h004B));
    add(0, 0, 1, 16'h0000, idle(16'h004B));
    add(0, 0, 1, 16'h0000, busy(16'h004B));
    add(0, 0, 0, 16'h0000, ex(0, 0, 8'h10, 3'd0, 3'd3, 2'd0, 2'd0, 16'h004B));
    add(0, 0, 0, 16'h0000, ex(0, 0, 8'h09, 3'd0, 3'd0, 2'b01, 2'b00, 16'h004B));
    add(0, 0, 0, 16'h0000, ex(0, 0, 8'h40, 3'd2, 3'd0, 2'd0, 2'd0, 16'h004B));
    add(0, 0, 0, 16'h0000, idle(16'h004B));
    // MVN R7, R2
    add(0, 1, 1, 16'hB8E2, busy(16'hFFE2));
    add(0, 0, 0, 16'h0000, ex(0, 0, 8'h10, 3'd0, 3'd2, 2'd0, 2'd0, 16'hFFE2));
    add(0, 0, 0, 16'h0000, ex(0, 0, 8'h01, 3'd0, 3'd0, 2'd0, 2'b11, 16'hFFE2));
    add(0, 0, 0, 16'h0000, ex(0, 0, 8'h40, 3'd7, 3'd0, 2'd0, 2'd0, 16'hFFE2));
    add(0, 0, 0, 16'h0000, idle(16'hFFE2));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].ld, tbl[i].st, tbl[i].ins, tbl[i].exp, i);
    end

    // illegal opcodes
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 1, bad[k], busy(16'h0000), 100 + 10 * k);
`ifdef ILLEGAL_TRAP_EN
      step(0, 0, 0, 16'h0000, ex(0, 1, 8'h00, 3'd0, 3'd0, 2'd0, 2'd0, 16'h0000), 101 + 10 * k);
      step(0, 1, 1, 16'hD007, ex(0, 1, 8'h00, 3'd0, 3'd0, 2'd0, 2'd0, 16'h0000), 102 + 10 * k);
      step(0, 1, 1, 16'hD007, ex(0, 1, 8'h00, 3'd0, 3'd0, 2'd0, 2'd0, 16'h0000), 103 + 10 * k);
      step(1, 0, 0, 16'h0000, idle(16'h0000), 104 + 10 * k);
`else
      step(0, 0, 0, 16'h0000, idle(16'h0000), 101 + 10 * k);
      step(0, 0, 0, 16'h0000, idle(16'h0000), 102 + 10 * k);
`endif
    end

    // reset in the middle of an ADD, observed at GET_B
    step(0, 1, 1, 16'hA148, busy(16'h0048), 200);
    step(0, 0, 0, 16'h0000, ex(0, 0, 8'h20, 3'd0, 3'd1, 2'd0, 2'd0, 16'h0048), 201);
    step(0, 0, 0, 16'h0000, ex(0, 0, 8'h10, 3'd0, 3'd0, 2'd0, 2'd0, 16'h0048), 202);
    step(1, 0, 0, 16'h0000, idle(16'h0000), 203);
    step(0, 0, 0, 16'h0000, idle(16'h0000), 204);
    step(0, 0, 0, 16'h0000, idle(16'h0000), 205);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
